// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR engine and its address generator.
package fir_pkg;

   localparam int NUM_TAP_DEF    = 11;
   localparam int ADDR_WIDTH_DEF = 12;
   localparam int BIT_WIDTH_DEF  = 32;
   localparam int LEN_WIDTH      = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      WAIT_IN = 3'd2,
      MAC     = 3'd3,
      OUT     = 3'd4
   } fir_state_t;

endpackage

// File: rtl/fir_addr_gen.sv
// Circular write pointer over the NUM_TAP-word history and the (wp - k) mod NUM_TAP read address.
module fir_addr_gen
   import fir_pkg::*;
#(
   parameter int NUM_TAP    = NUM_TAP_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  advance,
   input  logic [ADDR_WIDTH-1:0] tap_idx,
   output logic [ADDR_WIDTH-1:0] wp,
   output logic [ADDR_WIDTH-1:0] rd_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_TAP - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(NUM_TAP);

   logic [ADDR_WIDTH-1:0] wp_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wp_reg <= '0;
      end else if (advance) begin
         wp_reg <= (wp_reg == LAST_ADDR) ? '0 : wp_reg + 1'b1;
      end
   end

   // Older samples sit behind wp; borrow one buffer length when k passes wp.
   always_comb begin
      if (wp_reg >= tap_idx) begin
         rd_addr = wp_reg - tap_idx;
      end else begin
         rd_addr = wp_reg + DEPTH - tap_idx;
      end
   end

   assign wp = wp_reg;

endmodule

// File: rtl/fir_engine.sv
// Streaming FIR: each input sample is written into a circular BRAM history, then NUM_TAP MACs run.
// Optional FIR_SATURATE_EN: double-width accumulator saturated to BIT_WIDTH; otherwise modulo wrap.
module fir_engine
   import fir_pkg::*;
#(
   parameter int NUM_TAP    = NUM_TAP_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int BIT_WIDTH  = BIT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ap_start,
   input  logic [LEN_WIDTH-1:0]  data_length,
   output logic                  ap_idle,
   output logic                  ap_done,
   input  logic                  ss_tvalid,
   input  logic [BIT_WIDTH-1:0]  ss_tdata,
   input  logic                  ss_tlast,
   output logic                  ss_tready,
   output logic                  sm_tvalid,
   output logic [BIT_WIDTH-1:0]  sm_tdata,
   output logic                  sm_tlast,
   input  logic                  sm_tready,
   output logic                  tap_re,
   output logic [ADDR_WIDTH-1:0] tap_raddr,
   input  logic [BIT_WIDTH-1:0]  tap_rdo,
   output logic                  data_we,
   output logic [ADDR_WIDTH-1:0] data_waddr,
   output logic [BIT_WIDTH-1:0]  data_wdi,
   output logic                  data_re,
   output logic [ADDR_WIDTH-1:0] data_raddr,
   input  logic [BIT_WIDTH-1:0]  data_rdo
);

`ifdef FIR_SATURATE_EN
   localparam int ACC_WIDTH = 2 * BIT_WIDTH;
`else
   localparam int ACC_WIDTH = BIT_WIDTH;
`endif

   localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NUM_TAP - 1);
   localparam logic [ADDR_WIDTH-1:0] MAC_END  = ADDR_WIDTH'(NUM_TAP);

   fir_state_t state_reg, state_next;
   logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
   logic                  done_next;
   logic [LEN_WIDTH-1:0]  length_reg;
   logic [LEN_WIDTH-1:0]  sample_cnt_reg;
   logic                  in_last_reg;
   logic                  last_reg;
   logic                  done_reg;
   logic [BIT_WIDTH-1:0]  result_reg;
   logic [BIT_WIDTH-1:0]  result_next;

   logic signed [ACC_WIDTH-1:0] acc_reg;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic signed [ACC_WIDTH-1:0] tap_ext;
   logic signed [ACC_WIDTH-1:0] data_ext;
   logic signed [ACC_WIDTH-1:0] product;

   logic                  wp_clear;
   logic                  wp_adv;
   logic                  in_hs;
   logic                  acc_en;
   logic                  mac_final;
   logic [ADDR_WIDTH-1:0] wp;
   logic [ADDR_WIDTH-1:0] hist_addr;

   fir_addr_gen #(
      .NUM_TAP    (NUM_TAP),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .clear   (wp_clear),
      .advance (wp_adv),
      .tap_idx (cnt_reg),
      .wp      (wp),
      .rd_addr (hist_addr)
   );

   // RAM data for the read issued at step k arrives while cnt_reg = k+1.
   assign tap_ext  = ACC_WIDTH'($signed(tap_rdo));
   assign data_ext = ACC_WIDTH'($signed(data_rdo));
   assign product  = tap_ext * data_ext;
   assign acc_sum  = acc_reg + product;

`ifdef FIR_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
      $signed({{(ACC_WIDTH - BIT_WIDTH + 1){1'b0}}, {(BIT_WIDTH - 1){1'b1}}});
   localparam logic signed [ACC_WIDTH-1:0] RES_MIN =
      $signed({{(ACC_WIDTH - BIT_WIDTH + 1){1'b1}}, {(BIT_WIDTH - 1){1'b0}}});

   always_comb begin
      if (acc_sum > RES_MAX) begin
         result_next = RES_MAX[BIT_WIDTH-1:0];
      end else if (acc_sum < RES_MIN) begin
         result_next = RES_MIN[BIT_WIDTH-1:0];
      end else begin
         result_next = acc_sum[BIT_WIDTH-1:0];
      end
   end
`else
   assign result_next = acc_sum;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      ap_idle    = 1'b0;
      ss_tready  = 1'b0;
      sm_tvalid  = 1'b0;
      data_we    = 1'b0;
      data_waddr = '0;
      data_wdi   = '0;
      tap_re     = 1'b0;
      tap_raddr  = '0;
      data_re    = 1'b0;
      data_raddr = '0;
      wp_clear   = 1'b0;
      wp_adv     = 1'b0;
      in_hs      = 1'b0;
      acc_en     = 1'b0;
      mac_final  = 1'b0;

      case (state_reg)
         IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end

         CLEAR: begin
            data_we    = 1'b1;
            data_waddr = cnt_reg;
            if (cnt_reg == LAST_TAP) begin
               cnt_next = '0;
               wp_clear = 1'b1;
               if (length_reg == '0) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = WAIT_IN;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         WAIT_IN: begin
            ss_tready = 1'b1;
            if (ss_tvalid) begin
               in_hs      = 1'b1;
               data_we    = 1'b1;
               data_waddr = wp;
               data_wdi   = ss_tdata;
               cnt_next   = '0;
               state_next = MAC;
            end
         end

         MAC: begin
            acc_en = (cnt_reg != '0);
            if (cnt_reg == MAC_END) begin
               mac_final  = 1'b1;
               state_next = OUT;
            end else begin
               tap_re     = 1'b1;
               data_re    = 1'b1;
               tap_raddr  = cnt_reg;
               data_raddr = hist_addr;
               cnt_next   = cnt_reg + 1'b1;
            end
         end

         OUT: begin
            sm_tvalid = 1'b1;
            if (sm_tready) begin
               wp_adv = 1'b1;
               if (last_reg) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = WAIT_IN;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         done_reg       <= 1'b0;
         length_reg     <= '0;
         sample_cnt_reg <= '0;
         in_last_reg    <= 1'b0;
         last_reg       <= 1'b0;
         acc_reg        <= '0;
         result_reg     <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;

         if (state_reg == IDLE && ap_start) begin
            length_reg <= data_length;
         end

         if (wp_clear) begin
            sample_cnt_reg <= '0;
         end else if (wp_adv) begin
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
         end

         if (in_hs) begin
            in_last_reg <= ss_tlast;
            acc_reg     <= '0;
         end else if (acc_en) begin
            acc_reg <= acc_sum;
         end

         // Frame ends on the length count or on an upstream tlast, whichever comes first.
         if (mac_final) begin
            result_reg <= result_next;
            last_reg   <= ((sample_cnt_reg + 1'b1) == length_reg) || in_last_reg;
         end
      end
   end

   assign ap_done  = done_reg;
   assign sm_tdata = result_reg;
   assign sm_tlast = last_reg && (state_reg == OUT);

endmodule

// File: tb/tb_fir_engine.sv
// Self-checking bench for fir_engine: random frames against a convolution model, scoreboard-checked.
module tb_fir_engine;

   localparam int NT = 11;
   localparam int AW = 12;
   localparam int BW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ap_start;
   logic [31:0]   data_length;
   logic          ap_idle;
   logic          ap_done;
   logic          ss_tvalid;
   logic [BW-1:0] ss_tdata;
   logic          ss_tlast;
   logic          ss_tready;
   logic          sm_tvalid;
   logic [BW-1:0] sm_tdata;
   logic          sm_tlast;
   logic          sm_tready;
   logic          tap_re;
   logic [AW-1:0] tap_raddr;
   logic [BW-1:0] tap_rdo;
   logic          data_we;
   logic [AW-1:0] data_waddr;
   logic [BW-1:0] data_wdi;
   logic          data_re;
   logic [AW-1:0] data_raddr;
   logic [BW-1:0] data_rdo;

   always #5 clk = ~clk;

   fir_engine #(
      .NUM_TAP    (NT),
      .ADDR_WIDTH (AW),
      .BIT_WIDTH  (BW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ap_start    (ap_start),
      .data_length (data_length),
      .ap_idle     (ap_idle),
      .ap_done     (ap_done),
      .ss_tvalid   (ss_tvalid),
      .ss_tdata    (ss_tdata),
      .ss_tlast    (ss_tlast),
      .ss_tready   (ss_tready),
      .sm_tvalid   (sm_tvalid),
      .sm_tdata    (sm_tdata),
      .sm_tlast    (sm_tlast),
      .sm_tready   (sm_tready),
      .tap_re      (tap_re),
      .tap_raddr   (tap_raddr),
      .tap_rdo     (tap_rdo),
      .data_we     (data_we),
      .data_waddr  (data_waddr),
      .data_wdi    (data_wdi),
      .data_re     (data_re),
      .data_raddr  (data_raddr),
      .data_rdo    (data_rdo)
   );

   // BRAM models with one-cycle registered read
   logic [BW-1:0] tap_mem  [0:4095];
   logic [BW-1:0] data_mem [0:4095];

   always @(posedge clk) begin
      if (tap_re)  tap_rdo  <= tap_mem[tap_raddr];
      if (data_re) data_rdo <= data_mem[data_raddr];
      if (data_we) data_mem[data_waddr] <= data_wdi;
   end

   typedef struct packed {
      logic [BW-1:0] data;
      logic          last;
   } exp_t;

   exp_t          exp_q [$];
   logic [BW-1:0] hist  [$];
   logic [BW-1:0] stim  [0:63];

   int n_cmp = 0;
   int n_err = 0;
   int out_cnt = 0;
   int done_cnt = 0;
   int out_base = 0;
   int rdy_mode = 0;
   int low_left = 0;
   bit noise = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference: direct convolution of the newest NT samples (newest first) with the taps.
   function automatic logic [BW-1:0] model_out();
      longint s = 0;
      for (int k = 0; k < NT; k++) begin
         s += longint'($signed(tap_mem[k])) * longint'($signed(hist[k]));
      end
`ifdef FIR_SATURATE_EN
      if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
      if (s < -64'sh80000000) return 32'h80000000;
`endif
      return s[BW-1:0];
   endfunction

   task automatic mon_pop();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_output: got data=%08h last=%0b, required no output", sm_tdata, sm_tlast);
      end else begin
         e = exp_q.pop_front();
         $display("out #%0d data=%08h last=%0b (model data=%08h last=%0b)",
                  out_cnt, sm_tdata, sm_tlast, e.data, e.last);
         check("out_data", sm_tdata, e.data);
         check("out_last", sm_tlast, e.last);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake, checks hold-stability under backpressure.
   logic          hold_prev = 1'b0;
   logic [BW-1:0] hold_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (ap_done) done_cnt <= done_cnt + 1;
         if (hold_prev) begin
            check("hold_valid", sm_tvalid, 1);
            check("hold_data", sm_tdata, hold_data);
         end
         if (sm_tvalid) begin
            check("ss_tready_in_out", ss_tready, 0);
            if (sm_tready) begin
               mon_pop();
               out_cnt   <= out_cnt + 1;
               hold_prev <= 1'b0;
            end else begin
               hold_prev <= 1'b1;
               hold_data <= sm_tdata;
            end
         end else begin
            hold_prev <= 1'b0;
         end
      end
   end

   // Output-side ready generator
   initial begin
      sm_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: sm_tready = ($urandom_range(0, 2) != 0);
            2: begin
               if (sm_tvalid && (out_cnt - out_base == 1) && low_left > 0) begin
                  sm_tready = 1'b0;
                  low_left--;
               end else begin
                  sm_tready = 1'b1;
               end
            end
            default: sm_tready = 1'b1;
         endcase
      end
   end

   task automatic send(input logic [BW-1:0] d, input logic lst, input int idx, input int len);
      int waitc;
      int lat;
      exp_t e;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      waitc = 0;
      while (!ss_tready && waitc < 400) begin @(posedge clk); #1; waitc++; end
      if (!ss_tready) begin
         check("ss_tready_timeout", ss_tready, 1);
         return;
      end
      ss_tvalid = 1'b1;
      ss_tdata  = d;
      ss_tlast  = lst;
      hist.push_front(d);
      void'(hist.pop_back());
      e.data = model_out();
      e.last = ((idx + 1) == len) || lst;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
      lat = 0;
      while (!sm_tvalid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         ap_start = noise && (lat == 3);
      end
      ap_start = 1'b0;
      check("latency", lat, NT + 1);
   endtask

   task automatic start_frame(input int len);
      out_base    = out_cnt;
      data_length = len;
      ap_start    = 1'b1;
      @(posedge clk);
      #1;
      ap_start = 1'b0;
      hist.delete();
      repeat (NT) hist.push_back('0);
   endtask

   task automatic run_frame(input int len, input int tlast_at);
      int n;
      int w;
      int done_base;
      n = (tlast_at >= 0 && tlast_at < len) ? tlast_at + 1 : len;
      done_base = done_cnt;
      start_frame(len);
      for (int i = 0; i < n; i++) send(stim[i], (i == tlast_at), i, len);
      w = 0;
      while (!ap_idle && w < 600) begin @(posedge clk); #1; w++; end
      check("frame_idle", ap_idle, 1);
      repeat (3) begin @(posedge clk); #1; end
      check("done_pulses", done_cnt - done_base, 1);
      check("frame_outputs", out_cnt - out_base, n);
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_idle"}, ap_idle, 1);
      check({name, "_ctl"}, {ap_done, ss_tready, sm_tvalid, sm_tlast, tap_re, data_re, data_we}, 0);
      check({name, "_addr"}, {tap_raddr, data_waddr, data_raddr}, 0);
      check({name, "_data"}, {data_wdi, sm_tdata}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int tl;
      rst = 1'b1;
      ap_start = 1'b0;
      data_length = '0;
      ss_tvalid = 1'b0;
      ss_tdata = '0;
      ss_tlast = 1'b0;
      for (int i = 0; i < 4096; i++) tap_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_reset", ap_idle, 1);

      // Impulse: outputs reproduce the taps 1..11
      for (int k = 0; k < NT; k++) tap_mem[k] = BW'(k + 1);
      for (int i = 0; i < 64; i++) stim[i] = '0;
      stim[0] = 32'd1;
      run_frame(11, -1);

      // Step through two pointer wraps
      for (int k = 0; k < NT; k++) tap_mem[k] = 32'd1;
      for (int i = 0; i < 64; i++) stim[i] = 32'd3;
      run_frame(25, -1);

      // Backpressure on the second output
      rdy_mode = 2;
      low_left = 5;
      for (int k = 0; k < NT; k++) tap_mem[k] = 32'($urandom_range(0, 200)) - 32'd100;
      for (int i = 0; i < 64; i++) stim[i] = 32'($urandom_range(0, 200)) - 32'd100;
      run_frame(6, -1);
      check("bp_low_cycles_used", low_left, 0);
      rdy_mode = 0;

      // Overflow boundary
      for (int k = 0; k < NT; k++) tap_mem[k] = 32'h7FFFFFFF;
      for (int i = 0; i < 64; i++) stim[i] = 32'd2;
      run_frame(3, -1);

      // Early upstream tlast on sample 6
      for (int k = 0; k < NT; k++) tap_mem[k] = $urandom;
      for (int i = 0; i < 64; i++) stim[i] = $urandom;
      run_frame(10, 5);

      // Zero-length frame
      run_frame(0, -1);

      // Random frames, random backpressure, stray ap_start while busy
      for (int f = 0; f < 5; f++) begin
         rdy_mode = 1;
         noise = 1'b1;
         for (int k = 0; k < NT; k++)
            tap_mem[k] = (f % 2 == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
         for (int i = 0; i < 64; i++)
            stim[i] = (f % 2 == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
         len = $urandom_range(1, 24);
         tl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         run_frame(len, tl);
      end
      rdy_mode = 0;
      noise = 1'b0;

      // Reset during the MAC of sample 4, then restart with a zeroed history
      for (int k = 0; k < NT; k++) tap_mem[k] = 32'($urandom_range(1, 50));
      for (int i = 0; i < 64; i++) stim[i] = 32'($urandom_range(1, 50));
      start_frame(10);
      for (int i = 0; i < 3; i++) send(stim[i], 1'b0, i, 10);
      tl = 0;
      while (!ss_tready && tl < 100) begin @(posedge clk); #1; tl++; end
      check("rst_test_ready", ss_tready, 1);
      ss_tvalid = 1'b1;
      ss_tdata  = stim[3];
      @(posedge clk);
      #1;
      ss_tvalid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_test_in_mac", tap_re, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("midframe_reset");
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rst_no_output", out_cnt - out_base, 3);
      check("rst_queue_empty", exp_q.size(), 0);
      for (int i = 0; i < 64; i++) stim[i] = 32'($urandom_range(1, 50));
      run_frame(8, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
